hc595_rx: RTL and testbench
===========================

Name: hc595_rx

Overview:
- Receive end of the 74HC595 serial display link (ds/shcp/stcp/oe) driven by the dynamic segment driver.
- Oversamples the pins on sys_clk, rebuilds each shift-register frame and latches it on the storage-clock edge.
- Decodes the segment byte of each valid frame into a per-digit symbol register for 6 digits.
- Used for board loopback checking and as the self-check monitor in display benches.

Parameters:
SR_WIDTH, 14, bits per frame (SEG_W + SEL_W)
SEG_W, 8, segment field width; bit 7 = dp, bits 6:0 = g..a, active-low
SEL_W, 6, digit-select field width, one-hot, active-high

Ports:
sys_clk  in  1  system clock, 50 MHz
sys_rst  in  1  asynchronous active-high reset
ds  in  1  serial data pin, asynchronous to sys_clk
shcp  in  1  shift clock pin, asynchronous
stcp  in  1  storage (latch) clock pin, asynchronous
oe  in  1  output enable pin, active-low, asynchronous
par_q  out  SR_WIDTH  last latched frame
frame_vld  out  1  one-cycle pulse: frame latched and well-formed
frame_err  out  1  one-cycle pulse: frame latched with wrong bit count or non-one-hot select
digits  out  30  6 x 5-bit symbol codes; digit i at [5i+4:5i]
dp  out  6  decimal-point state per digit, 1 = lit
disp_en  out  1  synchronised ~oe

Behaviour:
- Reset (async, active-high): all sync flops, shift register and bit counter = 0; par_q = 0; frame_vld = frame_err = 0; every digits field = 16 (blank); dp = 0; disp_en = 0.
- Input sync: ds, shcp, stcp, oe each pass through 2 flops, then a third flop for edge detection. Rising edge = (prev == 0 && cur == 1). Pin highs and lows are 2 or more sys_clk cycles wide.
- Shift: on a shcp rising edge, sr <= {sr[SR_WIDTH-2:0], ds_sync}. The first bit sent ends up at the MSB after SR_WIDTH shifts. bit_cnt increments and saturates at 31.
- Latch: on a stcp rising edge:
  - par_q <= sr.
  - bit_cnt resets to 0.
  - Output pulse is one cycle after the detected edge. frame_vld if bit_cnt == SR_WIDTH and the select field par[SEL_W-1:0] is one-hot; otherwise frame_err.
- Shift and latch on the same sample: latch takes sr before that shift. The new bit counts as bit 1 of the next frame (bit_cnt = 1).
- Field split: seg = par_q[SR_WIDTH-1:SEL_W], sel = par_q[SEL_W-1:0]. Digit index = position of the set sel bit.
- Decode: on frame_vld, the selected digit field and dp bit update in the same cycle as the pulse (registered from the pre-latch sr). Other digits hold.
  - seg[6:0] to code: 40→0, 79→1, 24→2, 30→3, 19→4, 12→5, 02→6, 78→7, 00→8, 10→9, 08→A(10), 03→b(11), 46→C(12), 21→d(13), 06→E(14), 0E→F(15), 7F→blank(16), 3F→minus(17); any other value→31.
  - dp[i] = ~seg[7].
- Error frames: par_q still updates; digits and dp are not touched.
- disp_en follows ~oe after the 2-flop sync (latency 2 cycles). It does not gate decoding.
- Idle: no edges → all state holds indefinitely. Extra shifts beyond SR_WIDTH discard the oldest bits; the frame is flagged on latch.
- Reset mid-frame: partial shift data is discarded, and the next stcp edge with bit_cnt != SR_WIDTH gives frame_err.

Test Plan:
1. Reset release, no pin activity for 1000 cycles → digits all 16, dp = 0, frame_vld and frame_err never assert.
2. Shift 14 bits of 0x3001 (seg C0, sel 000001), then pulse stcp → par_q = 14'h3001, one frame_vld pulse, digits[4:0] = 0, dp[0] = 0, other digits stay 16.
3. Frame seg 0x12 (dp lit), sel 100000 → digits[29:25] = 5, dp[5] = 1. Follow with 13-bit frame then stcp → frame_err, digit 5 unchanged.
4. Sel 000011 with 14 bits → frame_err. Seg 0xFF, sel 000100 → digit 2 = 16. Seg 0x55 → code 31 with frame_vld.
5. shcp and stcp rising on the same sample after 14 shifts → par_q equals the pre-shift sr, frame_vld, next frame needs 13 more shifts to be valid.
6. oe low→high→low → disp_en 1→0→1, each change 2 cycles after the pin. Assert sys_rst after 7 shifts → all outputs return to reset values immediately.

Source files
------------

// File: rtl/hc595_rx.sv
// Receive side of the 74HC595 display link: synchronises ds/shcp/stcp/oe, rebuilds
// each shift-register frame, latches it on stcp and decodes the segment byte per digit.
module hc595_rx #(
  parameter int SR_WIDTH = 14,
  parameter int SEG_W    = 8,
  parameter int SEL_W    = 6
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  input  logic                  ds,
  input  logic                  shcp,
  input  logic                  stcp,
  input  logic                  oe,
  output logic [SR_WIDTH-1:0]   par_q,
  output logic                  frame_vld,
  output logic                  frame_err,
  output logic [5*SEL_W-1:0]    digits,
  output logic [SEL_W-1:0]      dp,
  output logic                  disp_en
);

  localparam logic [4:0] CODE_BLANK = 5'd16;
  localparam logic [4:0] CNT_MAX    = 5'd31;

  logic [1:0]          r_ds_sync;
  logic [2:0]          r_shcp_sync;
  logic [2:0]          r_stcp_sync;
  logic [1:0]          r_oen_sync;
  logic [SR_WIDTH-1:0] r_sr;
  logic [4:0]          r_bit_cnt;
  logic [SR_WIDTH-1:0] r_par_q;
  logic                r_frame_vld;
  logic                r_frame_err;
  logic [4:0]          r_digits [SEL_W];
  logic [SEL_W-1:0]    r_dp;

  logic                w_shift;
  logic                w_latch;
  logic [SEG_W-1:0]    w_seg;
  logic [SEL_W-1:0]    w_sel;
  logic                w_sel_onehot;
  logic                w_frame_ok;
  logic [4:0]          w_code;

  // Active-low segment pattern (g..a) to symbol code; 31 marks an unknown pattern.
  function automatic logic [4:0] seg_to_code(input logic [6:0] seg);
    case (seg)
      7'h40:   seg_to_code = 5'd0;
      7'h79:   seg_to_code = 5'd1;
      7'h24:   seg_to_code = 5'd2;
      7'h30:   seg_to_code = 5'd3;
      7'h19:   seg_to_code = 5'd4;
      7'h12:   seg_to_code = 5'd5;
      7'h02:   seg_to_code = 5'd6;
      7'h78:   seg_to_code = 5'd7;
      7'h00:   seg_to_code = 5'd8;
      7'h10:   seg_to_code = 5'd9;
      7'h08:   seg_to_code = 5'd10;
      7'h03:   seg_to_code = 5'd11;
      7'h46:   seg_to_code = 5'd12;
      7'h21:   seg_to_code = 5'd13;
      7'h06:   seg_to_code = 5'd14;
      7'h0E:   seg_to_code = 5'd15;
      7'h7F:   seg_to_code = 5'd16;
      7'h3F:   seg_to_code = 5'd17;
      default: seg_to_code = 5'd31;
    endcase
  endfunction

  // oe is synchronised already inverted so the reset value of the chain gives disp_en = 0.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_ds_sync   <= '0;
      r_shcp_sync <= '0;
      r_stcp_sync <= '0;
      r_oen_sync  <= '0;
    end else begin
      // NOTE: non-blocking assignments let every stage sample the previous stage's old value.
      r_ds_sync   <= {r_ds_sync[0], ds};
      r_shcp_sync <= {r_shcp_sync[1:0], shcp};
      r_stcp_sync <= {r_stcp_sync[1:0], stcp};
      r_oen_sync  <= {r_oen_sync[0], ~oe};
    end
  end

  assign w_shift = r_shcp_sync[1] & ~r_shcp_sync[2];
  assign w_latch = r_stcp_sync[1] & ~r_stcp_sync[2];

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    w_seg        = r_sr[SR_WIDTH-1 -: SEG_W];
    w_sel        = r_sr[SEL_W-1:0];
    w_sel_onehot = (w_sel != '0) && ((w_sel & (w_sel - SEL_W'(1))) == '0);
    w_frame_ok   = w_sel_onehot && (r_bit_cnt == 5'(SR_WIDTH));
    w_code       = seg_to_code(w_seg[6:0]);
  end

  // A shift coinciding with a latch counts as the first bit of the next frame.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_sr      <= '0;
      r_bit_cnt <= '0;
    end else begin
      if (w_shift) r_sr <= {r_sr[SR_WIDTH-2:0], r_ds_sync[1]};
      if (w_latch)
        r_bit_cnt <= w_shift ? 5'd1 : 5'd0;
      else if (w_shift && r_bit_cnt != CNT_MAX)
        r_bit_cnt <= r_bit_cnt + 5'd1;
    end
  end

  // Latch and decode both read the pre-shift sr so digits update with the frame_vld pulse.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_par_q     <= '0;
      r_frame_vld <= 1'b0;
      r_frame_err <= 1'b0;
      r_dp        <= '0;
      // NOTE: the digit array is a handful of flops, not RAM, so each entry resets to blank.
      for (int i = 0; i < SEL_W; i++) r_digits[i] <= CODE_BLANK;
    end else begin
      r_frame_vld <= w_latch & w_frame_ok;
      r_frame_err <= w_latch & ~w_frame_ok;
      if (w_latch) r_par_q <= r_sr;
      if (w_latch && w_frame_ok) begin
        for (int i = 0; i < SEL_W; i++) begin
          if (w_sel[i]) begin
            r_digits[i] <= w_code;
            r_dp[i]     <= ~w_seg[SEG_W-1];
          end
        end
      end
    end
  end

  always_comb begin
    digits = '0;
    for (int i = 0; i < SEL_W; i++) digits[5*i +: 5] = r_digits[i];
  end

  assign par_q     = r_par_q;
  assign frame_vld = r_frame_vld;
  assign frame_err = r_frame_err;
  assign dp        = r_dp;
  assign disp_en   = r_oen_sync[1];

endmodule

// File: tb/tb_hc595_rx.sv
// Bench for hc595_rx: drives the pins like the display driver would and compares against
// a frame model built from the bit history (last 14 bits, count since last latch).
module tb_hc595_rx;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b0;
  logic        ds = 1'b0, shcp = 1'b0, stcp = 1'b0, oe = 1'b1;
  logic [13:0] par_q;
  logic        frame_vld, frame_err;
  logic [29:0] digits;
  logic [5:0]  dp;
  logic        disp_en;

  hc595_rx dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .ds(ds), .shcp(shcp), .stcp(stcp), .oe(oe),
    .par_q(par_q), .frame_vld(frame_vld), .frame_err(frame_err),
    .digits(digits), .dp(dp), .disp_en(disp_en)
  );

  always #10 sys_clk = ~sys_clk;

  int errors = 0;
  int checks = 0;
  int vld_seen = 0;
  int err_seen = 0;

  always @(negedge sys_clk) begin
    if (frame_vld) vld_seen++;
    if (frame_err) err_seen++;
  end

  // Reference model
  logic [6:0]  seg_tab [18] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00,
                                7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E, 7'h7F, 7'h3F};
  bit          hist[$];
  int          since_latch;
  logic [13:0] m_par;
  logic [4:0]  m_digits [6];
  logic [5:0]  m_dp;
  int          m_vld, m_err;

  function automatic logic [4:0] ref_code(input logic [6:0] s);
    for (int k = 0; k < 18; k++) if (seg_tab[k] == s) return 5'(k);
    return 5'd31;
  endfunction

  function automatic logic [29:0] exp_digits();
    logic [29:0] v;
    for (int i = 0; i < 6; i++) v[5*i +: 5] = m_digits[i];
    return v;
  endfunction

  task automatic model_reset();
    hist.delete();
    since_latch = 0;
    m_par = '0;
    m_dp = '0;
    for (int i = 0; i < 6; i++) m_digits[i] = 5'd16;
  endtask

  task automatic model_shift(input bit b);
    hist.push_back(b);
    if (since_latch < 31) since_latch++;
  endtask

  task automatic model_latch();
    logic [13:0] f = '0;
    for (int k = 0; k < 14; k++) begin
      int pos = hist.size() - 1 - k;
      if (pos >= 0 && hist[pos]) f += 14'(1 << k);
    end
    m_par = f;
    if (since_latch == 14 && $countones(f[5:0]) == 1) begin
      m_vld++;
      m_digits[$clog2(f[5:0])] = ref_code(f[12:6]);
      m_dp[$clog2(f[5:0])] = ~f[13];
    end else begin
      m_err++;
    end
    since_latch = 0;
  endtask

  // Pin drivers
  task automatic cyc(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic shift_bit(input bit b);
    ds = b; cyc(3);
    shcp = 1'b1; cyc(3);
    shcp = 1'b0;
    model_shift(b);
  endtask

  task automatic send_bits(input logic [19:0] w, input int n);
    for (int i = n - 1; i >= 0; i--) shift_bit(w[i]);
  endtask

  task automatic latch();
    stcp = 1'b1; cyc(3);
    stcp = 1'b0; cyc(4);
    model_latch();
  endtask

  task automatic shift_and_latch(input bit b);
    ds = b; cyc(3);
    shcp = 1'b1; stcp = 1'b1; cyc(3);
    shcp = 1'b0; stcp = 1'b0; cyc(4);
    model_latch();
    model_shift(b);
  endtask

  task automatic test_reset();
    model_reset();
    #5 sys_rst = 1'b1;
    #1;
    checks++; if (digits !== exp_digits()) begin errors++; $display("FAIL reset_digits: got %h want %h", digits, exp_digits()); end
    checks++; if ({par_q, frame_vld, frame_err, dp, disp_en} !== '0) begin errors++; $display("FAIL reset_outs: got par_q=%h vld=%b err=%b dp=%b en=%b want all 0", par_q, frame_vld, frame_err, dp, disp_en); end
    cyc(3);
    sys_rst = 1'b0;
    cyc(1000);
    checks++; if (digits !== exp_digits()) begin errors++; $display("FAIL idle_digits: got %h want %h", digits, exp_digits()); end
    checks++; if (dp !== 6'h0 || par_q !== 14'h0) begin errors++; $display("FAIL idle_dp_par: got dp=%b par_q=%h want 0", dp, par_q); end
    checks++; if (vld_seen + err_seen !== 0) begin errors++; $display("FAIL idle_pulses: got %0d want 0", vld_seen + err_seen); end
  endtask

  task automatic test_basic_frame();
    send_bits(20'h3001, 14);
    latch();
    checks++; if (par_q !== 14'h3001) begin errors++; $display("FAIL basic_par: got %h want 3001", par_q); end
    checks++; if (vld_seen !== m_vld || err_seen !== m_err) begin errors++; $display("FAIL basic_pulse: got vld=%0d err=%0d want %0d %0d", vld_seen, err_seen, m_vld, m_err); end
    checks++; if (digits !== {5'd16, 5'd16, 5'd16, 5'd16, 5'd16, 5'd0}) begin errors++; $display("FAIL basic_digits: got %h want digit0=0 rest 16", digits); end
    checks++; if (dp !== 6'b0) begin errors++; $display("FAIL basic_dp: got %b want 0", dp); end
  endtask

  task automatic test_dp_and_short();
    send_bits({6'h0, 8'h12, 6'b100000}, 14);
    latch();
    checks++; if (digits[29:25] !== 5'd5 || dp[5] !== 1'b1) begin errors++; $display("FAIL dp_digit5: got code=%0d dp=%b want 5 1", digits[29:25], dp[5]); end
    send_bits(20'h01235, 13);
    latch();
    checks++; if (err_seen !== m_err || vld_seen !== m_vld) begin errors++; $display("FAIL short_err: got vld=%0d err=%0d want %0d %0d", vld_seen, err_seen, m_vld, m_err); end
    checks++; if (par_q !== m_par) begin errors++; $display("FAIL short_par: got %h want %h", par_q, m_par); end
    checks++; if (digits[29:25] !== 5'd5 || dp !== m_dp) begin errors++; $display("FAIL short_hold: got code=%0d dp=%b want 5 %b", digits[29:25], dp, m_dp); end
  endtask

  task automatic test_select_and_codes();
    send_bits({6'h0, 8'h40, 6'b000011}, 14);
    latch();
    checks++; if (err_seen !== m_err || digits !== exp_digits()) begin errors++; $display("FAIL twohot_err: got err=%0d digits=%h want %0d %h", err_seen, digits, m_err, exp_digits()); end
    send_bits({6'h0, 8'h79, 6'b000100}, 14);
    latch();
    checks++; if (digits[14:10] !== 5'd1 || dp[2] !== 1'b1) begin errors++; $display("FAIL digit2_one: got %0d dp=%b want 1 1", digits[14:10], dp[2]); end
    send_bits({6'h0, 8'hFF, 6'b000100}, 14);
    latch();
    checks++; if (digits[14:10] !== 5'd16 || dp[2] !== 1'b0) begin errors++; $display("FAIL digit2_blank: got %0d dp=%b want 16 0", digits[14:10], dp[2]); end
    send_bits({6'h0, 8'h55, 6'b000010}, 14);
    latch();
    checks++; if (digits[9:5] !== 5'd31 || vld_seen !== m_vld) begin errors++; $display("FAIL illegal_code: got %0d vld=%0d want 31 %0d", digits[9:5], vld_seen, m_vld); end
  endtask

  task automatic test_shift_latch_same_sample();
    send_bits({6'h0, 8'hA4, 6'b000010}, 14);
    shift_and_latch(1'b1);
    checks++; if (par_q !== 14'h2902 || vld_seen !== m_vld || err_seen !== m_err) begin errors++; $display("FAIL same_latch: got par=%h vld=%0d err=%0d want 2902 %0d %0d", par_q, vld_seen, err_seen, m_vld, m_err); end
    checks++; if (digits[9:5] !== 5'd2) begin errors++; $display("FAIL same_digit: got %0d want 2", digits[9:5]); end
    send_bits({6'h0, 8'hF9, 6'b001000}, 13);
    latch();
    checks++; if (par_q !== 14'h3E48 || vld_seen !== m_vld) begin errors++; $display("FAIL same_next: got par=%h vld=%0d want 3e48 %0d", par_q, vld_seen, m_vld); end
    checks++; if (digits[19:15] !== 5'd1 || dp !== m_dp) begin errors++; $display("FAIL same_next_dig: got %0d dp=%b want 1 %b", digits[19:15], dp, m_dp); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 24; n++) begin
      int          len;
      logic [7:0]  seg;
      logic [5:0]  sel;
      len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(12, 16)) : 14;
      seg = ($urandom_range(0, 1) == 1) ? {1'($urandom), seg_tab[$urandom_range(0, 17)]} : 8'($urandom);
      sel = ($urandom_range(0, 4) == 0) ? 6'($urandom) : 6'(1 << $urandom_range(0, 5));
      send_bits({6'($urandom), seg, sel}, len);
      latch();
      checks++; if (par_q !== m_par) begin errors++; $display("FAIL rand_par[%0d]: got %h want %h", n, par_q, m_par); end
      checks++; if (vld_seen !== m_vld || err_seen !== m_err) begin errors++; $display("FAIL rand_pulse[%0d]: got vld=%0d err=%0d want %0d %0d", n, vld_seen, err_seen, m_vld, m_err); end
      checks++; if (digits !== exp_digits() || dp !== m_dp) begin errors++; $display("FAIL rand_decode[%0d]: got %h/%b want %h/%b", n, digits, dp, exp_digits(), m_dp); end
    end
  endtask

  task automatic test_oe_and_reset();
    logic [5:0] pat = 6'b010101;
    for (int k = 0; k < 3; k++) begin
      logic want_new;
      oe = (k == 1);
      want_new = ~oe;
      cyc(1);
      checks++; if (disp_en !== ~want_new) begin errors++; $display("FAIL oe_early[%0d]: got %b want %b", k, disp_en, ~want_new); end
      cyc(1);
      checks++; if (disp_en !== want_new) begin errors++; $display("FAIL oe_follow[%0d]: got %b want %b", k, disp_en, want_new); end
    end
    send_bits({14'h0, pat}, 7);
    #5 sys_rst = 1'b1;
    #1;
    model_reset();
    checks++; if (digits !== exp_digits()) begin errors++; $display("FAIL midrst_digits: got %h want %h", digits, exp_digits()); end
    checks++; if ({par_q, frame_vld, frame_err, dp, disp_en} !== '0) begin errors++; $display("FAIL midrst_outs: got par_q=%h dp=%b en=%b want 0", par_q, dp, disp_en); end
    cyc(2);
    sys_rst = 1'b0;
    cyc(3);
    latch();
    checks++; if (err_seen !== m_err || vld_seen !== m_vld || par_q !== 14'h0) begin errors++; $display("FAIL midrst_latch: got err=%0d vld=%0d par=%h want %0d %0d 0", err_seen, vld_seen, par_q, m_err, m_vld); end
  endtask

  initial begin
    m_vld = 0;
    m_err = 0;
    test_reset();
    test_basic_frame();
    test_dp_and_short();
    test_select_and_codes();
    test_shift_latch_same_sample();
    test_random();
    test_oe_and_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
